// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Index `offset` positions after `base` in a ring of `n` requesters; expects base, offset < n.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + offset;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rr_stream_arb_pipeline_reg.sv
// Single-entry valid/ready register slice (module pipeline_reg) used as the arbiter output stage.
module pipeline_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // Ready while empty or draining this cycle, so a pop and a push can share one edge.
    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rr_stream_arb.sv
// Round-robin N:1 stream arbiter with a registered output stage.
// Define RR_STREAM_ARB_LOCK_EN to hold the grant for the whole packet (until in_last).
module rr_stream_arb
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ*WIDTH-1:0]   in_data,
    input  logic [NUM_REQ-1:0]         in_valid,
    input  logic [NUM_REQ-1:0]         in_last,
    output logic [NUM_REQ-1:0]         in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = WIDTH + 1 + IDW;

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rr_grant;
    logic [IDW-1:0]     rr_id;
    logic               rr_vld;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_vld;
    logic               stage_ready;
    logic               accept;
    logic               acc_last;
    logic [PW-1:0]      pipe_in;
    logic [PW-1:0]      pipe_out;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        rr_grant = '0;
        rr_id    = '0;
        rr_vld   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = wrap_idx(32'(ptr_q), 32'(k), 32'(NUM_REQ));
            if (in_valid[idx]) begin
                rr_grant      = '0;
                rr_grant[idx] = 1'b1;
                rr_id         = IDW'(idx);
                rr_vld        = 1'b1;
            end
        end
    end

`ifdef RR_STREAM_ARB_LOCK_EN
    lock_state_e    lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    always_comb begin
        grant     = rr_grant;
        grant_id  = rr_id;
        grant_vld = rr_vld;
        if (lock_q == LOCKED) begin
            grant     = '0;
            grant_id  = lock_id_q;
            grant_vld = in_valid[lock_id_q];
            grant[lock_id_q] = in_valid[lock_id_q];
        end
    end

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        case (lock_q)
            IDLE: begin
                if (accept && !acc_last) begin
                    lock_d    = LOCKED;
                    lock_id_d = grant_id;
                end
            end
            LOCKED: begin
                if (accept && acc_last) begin
                    lock_d = IDLE;
                end
            end
            default: lock_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= IDLE;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign grant     = rr_grant;
    assign grant_id  = rr_id;
    assign grant_vld = rr_vld;
`endif

    assign in_ready = grant & {NUM_REQ{stage_ready}};
    assign accept   = grant_vld && stage_ready;
    assign acc_last = in_last[grant_id];
    assign pipe_in  = {grant_id, acc_last, in_data[32'(grant_id) * WIDTH +: WIDTH]};

    // With locking, the pointer only advances once a packet completes.
    always_comb begin
        ptr_d = ptr_q;
`ifdef RR_STREAM_ARB_LOCK_EN
        if (accept && acc_last) begin
`else
        if (accept) begin
`endif
            ptr_d = IDW'(wrap_idx(32'(grant_id), 32'd1, 32'(NUM_REQ)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    pipeline_reg #(
        .WIDTH (PW)
    ) u_out_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (pipe_in),
        .valid_i (grant_vld),
        .ready_o (stage_ready),
        .data_o  (pipe_out),
        .valid_o (out_valid),
        .ready_i (out_ready)
    );

    assign out_id   = pipe_out[PW-1 -: IDW];
    assign out_last = pipe_out[WIDTH];
    assign out_data = pipe_out[WIDTH-1:0];

endmodule

// File: tb/tb_rr_stream_arb.sv
// Scoreboard bench for rr_stream_arb; follows RR_STREAM_ARB_LOCK_EN if defined.
module tb_rr_stream_arb;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR*W-1:0] in_data;
    logic [NR-1:0]   in_valid;
    logic [NR-1:0]   in_last;
    logic [NR-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_id;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;

    always #5 clk = ~clk;

    rr_stream_arb #(
        .NUM_REQ (NR),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [W-1:0] d;
        int           id;
        bit           last;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beat_cnt[NR];
    int    pkt_len[NR];
    bit    force_a5;
    int    m_ptr;
    bit    m_locked;
    int    m_lock_id;
    bit    m_ov;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready))
        else $error("FAIL a_onehot0 in_ready=%b required at most one bit set", in_ready);
    assert property (@(posedge clk) disable iff (!rst_n)
                     (out_valid && !out_ready) |=> $stable({out_data, out_id}))
        else $error("FAIL a_stable out_data=%h out_id=%0d required unchanged while stalled",
                    out_data, out_id);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] beat_data(input int i);
        return force_a5 ? 32'hA5A5A5A5 : {4'(i), 4'hC, 24'(beat_cnt[i])};
    endfunction

    function automatic bit beat_last(input int i);
        return (beat_cnt[i] % pkt_len[i]) == pkt_len[i] - 1;
    endfunction

    function automatic int model_grant();
        if (m_locked) begin
            return in_valid[m_lock_id] ? m_lock_id : -1;
        end
        for (int n = 0; n < NR; n++) begin
            int c = (m_ptr + n) % NR;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_lock_id = 0;
        m_ov      = 1'b0;
        sb_q.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            in_data[i*W +: W] = beat_data(i);
            in_last[i]        = beat_last(i);
        end
    endtask

    // One clock: drive, predict and compare at the falling edge, then advance the model.
    task automatic step();
        int              g;
        bit              sr;
        logic [NR-1:0]   exp_rdy;
        beat_t           e;
        drive();
        @(negedge clk);
        g       = model_grant();
        sr      = !m_ov || out_ready;
        exp_rdy = '0;
        if (g >= 0 && sr) exp_rdy[g] = 1'b1;
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check_eq("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q[0];
                check_eq("out_data", out_data, e.d);
                check_eq("out_id", out_id, e.id);
                check_eq("out_last", out_last, e.last);
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    $display("beat id=%0d data=%08h last=%0b", e.id, e.d, e.last);
                end
            end
        end
        if (m_ov && out_ready) m_ov = 1'b0;
        if (g >= 0 && sr) begin
            e.d    = beat_data(g);
            e.id   = g;
            e.last = beat_last(g);
            sb_q.push_back(e);
            m_ov = 1'b1;
            beat_cnt[g]++;
`ifdef RR_STREAM_ARB_LOCK_EN
            if (!m_locked && !e.last) begin
                m_locked  = 1'b1;
                m_lock_id = g;
            end else if (m_locked && e.last) begin
                m_locked = 1'b0;
            end
            if (e.last) m_ptr = (g + 1) % NR;
`else
            m_ptr = (g + 1) % NR;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [NR-1:0] v, input bit rdy, input int n);
        in_valid  = v;
        out_ready = rdy;
        repeat (n) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_out_data"}, out_data, '0);
        check_eq({tag, "_out_id"}, out_id, '0);
        check_eq({tag, "_out_last"}, out_last, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        force_a5  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            beat_cnt[i] = 0;
            pkt_len[i]  = 1;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check_eq("rst_in_ready", in_ready, '0);
        rst_n = 1'b1;

        // All requesters valid, single-beat packets: ids rotate 0,1,2,3,0,...
        run(4'hF, 1'b1, 8);
        // Only req 2 valid twice (second time with ptr at 3), then all valid.
        run(4'h4, 1'b1, 2);
        run(4'hF, 1'b1, 1);
        run(4'h0, 1'b1, 2);

        // Stall a 0xA5A5A5A5 beat for five cycles with everyone requesting.
        force_a5 = 1'b1;
        run(4'h1, 1'b1, 1);
        force_a5 = 1'b0;
        run(4'hF, 1'b0, 5);
        run(4'h0, 1'b1, 2);

        // Req 1 sends 3-beat packets while req 0 and 2 stay valid.
        for (int i = 0; i < NR; i++) beat_cnt[i] = 0;
        pkt_len[1] = 3;
        run(4'h1, 1'b1, 1);
        run(4'h7, 1'b1, 6);
        run(4'h0, 1'b1, 2);

        for (int i = 0; i < NR; i++) begin
            beat_cnt[i] = 0;
            pkt_len[i]  = $urandom_range(1, 4);
        end
        repeat (300) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset between clock edges with a beat held in the output stage.
        for (int i = 0; i < NR; i++) pkt_len[i] = 4;
        run(4'b1010, 1'b0, 3);
        check_eq("pre_rst_valid", out_valid, m_ov);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(4'b1010, 1'b1, 4);
        run(4'h0, 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_stream_arb.md
RR_STREAM_ARB -- requirements
Module: rr_stream_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  NUM_REQ x WIDTH  per-requester payload.
REQ-006 SHALL have port in_valid  input  NUM_REQ  per-requester valid.
REQ-007 SHALL have port in_last  input  NUM_REQ  per-requester last beat of packet.
REQ-008 SHALL have port in_ready  output  NUM_REQ  per-requester ready.
REQ-009 SHALL have port out_data  output  WIDTH  registered payload.
REQ-010 SHALL have port out_id  output  $clog2(NUM_REQ)  index of source requester.
REQ-011 SHALL have port out_last  output  1  registered last flag.
REQ-012 SHALL have port out_valid  output  1  output valid.
REQ-013 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-014 SHALL define stage_ready = !out_valid || out_ready; beat i accepted when in_valid[i] && in_ready[i].
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[i] = grant[i] && stage_ready.
REQ-016 SHALL grant only a requester whose in_valid is high; no valid -> grant all-zero.
REQ-017 SHALL select round-robin: search starts at pointer ptr, ascending, wrapping NUM_REQ-1 -> 0.
REQ-018 SHALL, on an accepted beat from requester i (unlocked mode), update ptr to (i+1) mod NUM_REQ; otherwise ptr holds.
REQ-019 SHALL register the accepted beat: out_data/out_last/out_id valid the cycle after acceptance (1-cycle latency).
REQ-020 SHALL sustain one beat per cycle when out_ready stays high (simultaneous pop and push on the same edge).
REQ-021 SHALL hold out_data/out_id/out_last/out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after out_valid && out_ready with no new acceptance in that cycle.
REQ-023 SHALL keep grant combinational from in_valid, ptr and lock state; in_ready SHALL NOT depend on in_data.

Reset
REQ-024 SHALL on rst_n low: out_valid=0, out_data=0, out_id=0, out_last=0, ptr=0, lock state IDLE, immediately (asynchronously).
REQ-025 SHALL drop an in-flight registered beat and any open lock on reset mid-packet; first grant after release starts at requester 0.

Configuration
REQ-026 SHALL use macro RR_STREAM_ARB_LOCK_EN to select packet locking.
REQ-027 SHALL, with RR_STREAM_ARB_LOCK_EN defined, implement FSM IDLE/LOCKED: IDLE -> LOCKED on accepted beat with in_last=0 (lock_id = source); LOCKED grants only lock_id (others see in_ready=0 even if valid); LOCKED -> IDLE on accepted beat from lock_id with in_last=1; ptr updates only on that last beat; a single-beat packet (in_last=1) never enters LOCKED.
REQ-028 SHALL, without the macro, arbitrate per beat, ignore in_last for grant purposes (still forwarded to out_last), and contain no lock state.

Structure
REQ-029 SHALL place in shared package rr_arb_pkg: lock-state enum (IDLE, LOCKED) and function for wrapped priority index.
REQ-030 SHALL instantiate pipeline_reg (WIDTH = WIDTH + 1 + $clog2(NUM_REQ)) as the output stage; grant/ptr/FSM logic lives in rr_stream_arb.

Verification
REQ-031 SHALL cover: all 4 valid, out_ready=1, single-beat packets -> out_id sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 SHALL cover: only req 2 valid, ptr=3 -> req 2 granted next cycle, ptr becomes 3.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with out_valid=1, out_data=0xA5A5A5A5 -> outputs stable, all in_ready=0, no beat lost.
REQ-034 SHALL cover (LOCK_EN): req 1 sends 3-beat packet (last on beat 3) while req 0,2 valid -> out_id 1,1,1 then 2, never interleaved.
REQ-035 SHALL cover: rst_n low mid-packet with out_valid=1 -> out_valid=0 same cycle, after release first grant to lowest valid index from 0.
REQ-036 SHALL check by assertion every cycle: $onehot0(in_ready), and out_valid && !out_ready |=> $stable(out_data, out_id).
